// File: rtl/turn_signal_pkg.sv
// Shared definitions for the turn-signal controller, its monitor and benches.
//   pat_e        : decoded tail-lamp pattern (legal steps plus ILLEGAL)
//   LAMP_*       : 6-bit lamp vectors, bit order {LC,LB,LA,RA,RB,RC}
//   MODE_*       : values of the monitor's mode output
//   ERR_*        : values of the monitor's err_code output
//   pat_mode / pat_phase / legal_step : decode and sequence helpers
package turn_signal_pkg;

  typedef enum logic [3:0] {
    PAT_IDLE    = 4'd0,
    PAT_L1      = 4'd1,
    PAT_L2      = 4'd2,
    PAT_L3      = 4'd3,
    PAT_R1      = 4'd4,
    PAT_R2      = 4'd5,
    PAT_R3      = 4'd6,
    PAT_HZ      = 4'd7,
    PAT_ILLEGAL = 4'd8
  } pat_e;

  localparam logic [5:0] LAMP_IDLE = 6'b000000;
  localparam logic [5:0] LAMP_L1   = 6'b001000;
  localparam logic [5:0] LAMP_L2   = 6'b011000;
  localparam logic [5:0] LAMP_L3   = 6'b111000;
  localparam logic [5:0] LAMP_R1   = 6'b000100;
  localparam logic [5:0] LAMP_R2   = 6'b000110;
  localparam logic [5:0] LAMP_R3   = 6'b000111;
  localparam logic [5:0] LAMP_HZ   = 6'b111111;

  localparam logic [2:0] MODE_IDLE    = 3'd0;
  localparam logic [2:0] MODE_LEFT    = 3'd1;
  localparam logic [2:0] MODE_RIGHT   = 3'd2;
  localparam logic [2:0] MODE_HAZARD  = 3'd3;
  localparam logic [2:0] MODE_UNKNOWN = 3'd7;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL_PAT = 3'd1;
  localparam logic [2:0] ERR_BAD_TRANS   = 3'd2;
  localparam logic [2:0] ERR_EARLY       = 3'd3;
  localparam logic [2:0] ERR_STUCK       = 3'd4;

  function automatic logic [2:0] pat_mode(input pat_e p);
    case (p)
      PAT_IDLE:                 return MODE_IDLE;
      PAT_L1, PAT_L2, PAT_L3:   return MODE_LEFT;
      PAT_R1, PAT_R2, PAT_R3:   return MODE_RIGHT;
      PAT_HZ:                   return MODE_HAZARD;
      default:                  return MODE_UNKNOWN;
    endcase
  endfunction

  function automatic logic [1:0] pat_phase(input pat_e p);
    case (p)
      PAT_L1, PAT_R1: return 2'd1;
      PAT_L2, PAT_R2: return 2'd2;
      PAT_L3, PAT_R3: return 2'd3;
      default:        return 2'd0;
    endcase
  endfunction

  // True when moving from 'from' to 'to' follows the flash sequence.
  // allow_abort additionally permits leaving a partial sequence for IDLE.
  function automatic logic legal_step(input pat_e from, input pat_e to,
                                      input logic allow_abort);
    if (from == to) return 1'b1;
    case (from)
      PAT_IDLE: return (to == PAT_L1) || (to == PAT_R1) || (to == PAT_HZ);
      PAT_L1:   return (to == PAT_L2) || (allow_abort && to == PAT_IDLE);
      PAT_L2:   return (to == PAT_L3) || (allow_abort && to == PAT_IDLE);
      PAT_R1:   return (to == PAT_R2) || (allow_abort && to == PAT_IDLE);
      PAT_R2:   return (to == PAT_R3) || (allow_abort && to == PAT_IDLE);
      PAT_L3, PAT_R3, PAT_HZ: return to == PAT_IDLE;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/turn_signal_pat_decode.sv
// Combinational lamp-vector decoder.
//   lamps : {LC,LB,LA,RA,RB,RC}
//   pat   : matching pattern, PAT_ILLEGAL when no legal pattern matches
//   legal : 1 when lamps is one of the eight legal patterns
module turn_signal_pat_decode
  import turn_signal_pkg::*;
(
  input  logic [5:0] lamps,
  output pat_e       pat,
  output logic       legal
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    pat   = PAT_ILLEGAL;
    legal = 1'b1;
    case (lamps)
      LAMP_IDLE: pat = PAT_IDLE;
      LAMP_L1:   pat = PAT_L1;
      LAMP_L2:   pat = PAT_L2;
      LAMP_L3:   pat = PAT_L3;
      LAMP_R1:   pat = PAT_R1;
      LAMP_R2:   pat = PAT_R2;
      LAMP_R3:   pat = PAT_R3;
      LAMP_HZ:   pat = PAT_HZ;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/turn_signal_monitor.sv
// Passive checker for the six tail-lamp outputs of the turn-signal controller.
// Decodes the lamps into mode/phase, checks sequence steps and dwell times,
// flags violations and counts completed flash cycles. All outputs registered.
//   Clk, Rst (async, active-low), en (0 freezes state)
//   LA..LC, RA..RC : lamp inputs
//   mode, phase    : decoded pattern (mode 7 on an error cycle)
//   err, err_code, err_cnt : violation pulse, last code, saturating count
//   cyc_done, cyc_cnt      : completion pulse, saturating count
module turn_signal_monitor
  import turn_signal_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 8,
  parameter int ALLOW_ABORT = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             en,
  input  logic             LA,
  input  logic             LB,
  input  logic             LC,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  output logic [2:0]       mode,
  output logic [1:0]       phase,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_cnt,
  output logic             cyc_done,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam int             DW        = $clog2(STEP_CYCLES + 1);
  localparam logic [DW-1:0]  DWELL_MAX = DW'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pat_e          cur_pat;
  logic          cur_legal;
  logic [2:0]    last_pat;   // only legal patterns are stored, so 3 bits suffice
  logic [DW-1:0] dwell;
  pat_e          last;
  logic          same;
  logic [2:0]    chk_code;
  logic          completes;

  turn_signal_pat_decode u_decode (
    .lamps ({LC, LB, LA, RA, RB, RC}),
    .pat   (cur_pat),
    .legal (cur_legal)
  );

  assign last = pat_e'({1'b0, last_pat});
  assign same = cur_legal && (cur_pat == last);

  // A completed cycle is the final step of a full sequence back to IDLE;
  // aborts from L1/L2/R1/R2 never reach here from L3/R3/HZ.
  assign completes = (cur_pat == PAT_IDLE) &&
                     ((last == PAT_L3) || (last == PAT_R3) || (last == PAT_HZ));

  // Checks in priority order; exactly one code per sample.
  always_comb begin
    chk_code = ERR_NONE;
    if (!cur_legal)
      chk_code = ERR_ILLEGAL_PAT;
    else if (!same && !legal_step(last, cur_pat, ALLOW_ABORT != 0))
      chk_code = ERR_BAD_TRANS;
    else if (!same && last != PAT_IDLE && dwell < DWELL_MAX)
      chk_code = ERR_EARLY;
    else if (same && last != PAT_IDLE && dwell == DWELL_MAX)
      chk_code = ERR_STUCK;
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      last_pat <= 3'(PAT_IDLE);
      dwell    <= '0;
      mode     <= MODE_IDLE;
      phase    <= 2'd0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      err_cnt  <= '0;
      cyc_done <= 1'b0;
      cyc_cnt  <= '0;
    end else if (!en) begin
      err      <= 1'b0;
      cyc_done <= 1'b0;
    end else if (chk_code != ERR_NONE) begin
      err      <= 1'b1;
      err_code <= chk_code;
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
      // Resync on what is actually on the lamps so one fault reports once.
      last_pat <= cur_legal ? 3'(cur_pat) : 3'(PAT_IDLE);
      dwell    <= DW'(1);
      mode     <= MODE_UNKNOWN;
      phase    <= 2'd0;
      cyc_done <= 1'b0;
    end else begin
      err      <= 1'b0;
      last_pat <= 3'(cur_pat);
      if (!same)                  dwell <= DW'(1);
      else if (dwell != DWELL_MAX) dwell <= dwell + 1'b1;
      mode     <= pat_mode(cur_pat);
      phase    <= pat_phase(cur_pat);
      cyc_done <= completes;
      if (completes && cyc_cnt != CNT_MAX) cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule
